// File: rtl/jtag_er1_dr_pkg.sv
// Shared types and default constants for the ER1 user data register.
package jtag_er1_dr_pkg;

  localparam int unsigned ER1_WIDTH      = 36;
  localparam logic [35:0] ER1_CAPTURE_ID = 36'h0_CAFE_0001;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURED = 2'd1,
    ST_SHIFTING = 2'd2,
    ST_COMMIT   = 2'd3
  } dr_state_e;

endpackage

// File: rtl/jtag_er1_dr_bit_counter.sv
// Saturating shift-bit counter with clear, enable and an equals-MATCH flag.
module dr_bit_counter #(
  parameter int unsigned LIMIT = 37,
  parameter int unsigned MATCH = 36,
  parameter int unsigned CW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          eq_match_c
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up until LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CW'(LIMIT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count      = cnt_q;
  assign eq_match_c = (cnt_q == CW'(MATCH));

endmodule

// File: rtl/jtag_er1_dr.sv
// ER1 user data register between JTAGG and the LED matrix driver.
module jtag_er1_dr
  import jtag_er1_dr_pkg::*;
#(
  parameter int unsigned     WIDTH      = ER1_WIDTH,
  parameter logic [WIDTH-1:0] CAPTURE_ID = WIDTH'(ER1_CAPTURE_ID)
) (
  input  logic             JTCK,
  input  logic             RESET,
  input  logic             JTDI,
  input  logic             JSHIFT,
  input  logic             JUPDATE,
  input  logic             JCE1,
  input  logic             JRTI1,
  input  logic             DATA_IN_SEL,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic             JTDO1,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             DATA_VALID,
  output logic             LEN_ERR,
  output logic             RTI_PULSE
);

  localparam int unsigned CW = $clog2(WIDTH + 2);

  dr_state_e        state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             armed_q, armed_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             len_err_q, len_err_d;
  logic             rti_hist_q, rti_hist_d;
  logic             rti_pulse_q, rti_pulse_d;

  logic             cnt_clr, cnt_en, cnt_full_c;
  logic [CW-1:0]    cnt;

  logic capture_c, shift_c, update_c, active_c;

  assign capture_c = JCE1 & ~JSHIFT;
  assign shift_c   = JCE1 & JSHIFT;
  assign update_c  = JUPDATE & armed_q;
  assign active_c  = (state_q == ST_CAPTURED) || (state_q == ST_SHIFTING);

  dr_bit_counter #(
    .LIMIT (WIDTH + 1),
    .MATCH (WIDTH),
    .CW    (CW)
  ) u_cnt (
    .clk        (JTCK),
    .rst        (RESET),
    .clr        (cnt_clr),
    .en         (cnt_en),
    .count      (cnt),
    .eq_match_c (cnt_full_c)
  );

  // Next-state and datapath decode; commit result is registered on the update
  // edge so DATA_OUT/DATA_VALID are visible during the COMMIT cycle.
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    armed_d      = armed_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    len_err_d    = len_err_q;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    rti_hist_d   = JRTI1;
    rti_pulse_d  = JRTI1 & ~rti_hist_q;

    if (state_q == ST_COMMIT) begin
      armed_d = 1'b0;
      state_d = ST_IDLE;
    end else if (capture_c) begin
      state_d = ST_CAPTURED;
      sr_d    = DATA_IN_SEL ? DATA_IN : CAPTURE_ID;
      cnt_clr = 1'b1;
      armed_d = 1'b1;
    end else if (active_c && shift_c) begin
      state_d = ST_SHIFTING;
      sr_d    = {JTDI, sr_q[WIDTH-1:1]};
      cnt_en  = 1'b1;
    end else if (active_c && update_c) begin
      state_d = ST_COMMIT;
      if (cnt_full_c) begin
        data_out_d   = sr_q;
        data_valid_d = 1'b1;
        len_err_d    = 1'b0;
      end else begin
        len_err_d    = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge JTCK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      sr_q         <= '0;
      armed_q      <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      len_err_q    <= 1'b0;
      rti_hist_q   <= 1'b0;
      rti_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      armed_q      <= armed_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      len_err_q    <= len_err_d;
      rti_hist_q   <= rti_hist_d;
      rti_pulse_q  <= rti_pulse_d;
    end
  end

  assign JTDO1      = sr_q[0];
  assign DATA_OUT   = data_out_q;
  assign DATA_VALID = data_valid_q;
  assign LEN_ERR    = len_err_q;
  assign RTI_PULSE  = rti_pulse_q;

endmodule

// File: tb/tb_jtag_er1_dr.sv
// Directed self-checking bench for jtag_er1_dr.
module tb_jtag_er1_dr;
  import jtag_er1_dr_pkg::*;

  logic        JTCK = 1'b0;
  logic        RESET = 1'b1;
  logic        JTDI = 1'b0;
  logic        JSHIFT = 1'b0;
  logic        JUPDATE = 1'b0;
  logic        JCE1 = 1'b0;
  logic        JRTI1 = 1'b0;
  logic        DATA_IN_SEL = 1'b0;
  logic [35:0] DATA_IN = '0;
  logic        JTDO1;
  logic [35:0] DATA_OUT;
  logic        DATA_VALID;
  logic        LEN_ERR;
  logic        RTI_PULSE;

  int errors = 0;
  int checks = 0;
  logic [35:0] tdo_v;

  jtag_er1_dr dut (
    .JTCK        (JTCK),
    .RESET       (RESET),
    .JTDI        (JTDI),
    .JSHIFT      (JSHIFT),
    .JUPDATE     (JUPDATE),
    .JCE1        (JCE1),
    .JRTI1       (JRTI1),
    .DATA_IN_SEL (DATA_IN_SEL),
    .DATA_IN     (DATA_IN),
    .JTDO1       (JTDO1),
    .DATA_OUT    (DATA_OUT),
    .DATA_VALID  (DATA_VALID),
    .LEN_ERR     (LEN_ERR),
    .RTI_PULSE   (RTI_PULSE)
  );

  always #5 JTCK = ~JTCK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge JTCK);
    #1;
  endtask

  task automatic capture(input logic sel, input logic [35:0] din);
    JCE1 = 1'b1; JSHIFT = 1'b0; DATA_IN_SEL = sel; DATA_IN = din;
    step();
    JCE1 = 1'b0;
  endtask

  task automatic shift(input int first, input int n, input logic [35:0] pat);
    for (int i = 0; i < n; i++) begin
      int idx;
      idx = first + i;
      JCE1 = 1'b1; JSHIFT = 1'b1;
      JTDI = (idx < 36) ? pat[idx] : 1'b0;
      if (idx < 36) tdo_v[idx] = JTDO1;
      step();
    end
    JCE1 = 1'b0; JSHIFT = 1'b0; JTDI = 1'b0;
  endtask

  task automatic update();
    JUPDATE = 1'b1;
    step();
    JUPDATE = 1'b0;
  endtask

  initial begin
    step(); step();
    RESET = 1'b0;
    check("rst_dout", 64'(DATA_OUT), 64'h0);
    check("rst_dv",   64'(DATA_VALID), 64'h0);
    check("rst_lerr", 64'(LEN_ERR), 64'h0);
    check("rst_tdo",  64'(JTDO1), 64'h0);
    check("rst_rti",  64'(RTI_PULSE), 64'h0);

    // JUPDATE with no capture since reset is ignored.
    update();
    check("noarm_dv",    64'(DATA_VALID), 64'h0);
    check("noarm_state", 64'(dut.state_q), 64'(ST_IDLE));
    step();
    check("noarm_dv2",   64'(DATA_VALID), 64'h0);

    // Full 36-bit transfer with CAPTURE_ID readback.
    tdo_v = '0;
    capture(1'b0, 36'h0);
    shift(0, 36, 36'h1_2345_6789);
    update();
    check("s1_dv",   64'(DATA_VALID), 64'h1);
    check("s1_dout", 64'(DATA_OUT), 64'h1_2345_6789);
    check("s1_lerr", 64'(LEN_ERR), 64'h0);
    check("s1_tdo",  64'(tdo_v), 64'h0_CAFE_0001);
    step();
    check("s1_dv_off", 64'(DATA_VALID), 64'h0);
    check("s1_idle",   64'(dut.state_q), 64'(ST_IDLE));

    // 35 shifts: length error, output held; DATA_IN readback.
    tdo_v = '0;
    capture(1'b1, 36'hF_0F0F_3C3C);
    shift(0, 35, 36'h0);
    check("s2_tdo", 64'(tdo_v[34:0]), 64'h7_0F0F_3C3C);
    update();
    check("s2_dv",   64'(DATA_VALID), 64'h0);
    check("s2_lerr", 64'(LEN_ERR), 64'h1);
    check("s2_dout", 64'(DATA_OUT), 64'h1_2345_6789);
    step();

    // Unarmed update leaves the sticky flag alone.
    update();
    check("unarm_lerr", 64'(LEN_ERR), 64'h1);
    check("unarm_dv",   64'(DATA_VALID), 64'h0);
    step();

    // Correct transfer clears the length error.
    capture(1'b0, 36'h0);
    shift(0, 36, 36'hA_5A5A_5A5A);
    update();
    check("s2b_dv",   64'(DATA_VALID), 64'h1);
    check("s2b_lerr", 64'(LEN_ERR), 64'h0);
    check("s2b_dout", 64'(DATA_OUT), 64'hA_5A5A_5A5A);
    step();

    // Zero shifts then update is a length error.
    capture(1'b0, 36'h0);
    update();
    check("zero_lerr", 64'(LEN_ERR), 64'h1);
    check("zero_dv",   64'(DATA_VALID), 64'h0);
    check("zero_dout", 64'(DATA_OUT), 64'hA_5A5A_5A5A);
    step();

    // 40 shifts saturate the counter at 37.
    capture(1'b0, 36'h0);
    shift(0, 40, 36'hF_FFFF_FFFF);
    check("s3_cnt", 64'(dut.u_cnt.count), 64'd37);
    update();
    check("s3_lerr", 64'(LEN_ERR), 64'h1);
    check("s3_dv",   64'(DATA_VALID), 64'h0);
    check("s3_dout", 64'(DATA_OUT), 64'hA_5A5A_5A5A);
    step();

    // Capture together with JUPDATE: capture wins.
    capture(1'b0, 36'h0);
    shift(0, 36, 36'h5_5555_5555);
    JCE1 = 1'b1; JSHIFT = 1'b0; JUPDATE = 1'b1;
    step();
    JCE1 = 1'b0; JUPDATE = 1'b0;
    check("cu_state", 64'(dut.state_q), 64'(ST_CAPTURED));
    check("cu_cnt",   64'(dut.u_cnt.count), 64'd0);
    check("cu_dv",    64'(DATA_VALID), 64'h0);
    step();
    check("cu_dv2",   64'(DATA_VALID), 64'h0);
    check("cu_dout",  64'(DATA_OUT), 64'hA_5A5A_5A5A);

    // JCE1 drop mid-shift holds, then resumes counting.
    capture(1'b0, 36'h0);
    shift(0, 10, 36'h9_8765_4321);
    step(); step(); step();
    check("drop_cnt",   64'(dut.u_cnt.count), 64'd10);
    check("drop_state", 64'(dut.state_q), 64'(ST_SHIFTING));
    shift(10, 26, 36'h9_8765_4321);
    update();
    check("drop_dv",   64'(DATA_VALID), 64'h1);
    check("drop_dout", 64'(DATA_OUT), 64'h9_8765_4321);
    step();

    // Reset mid-shift, with update and shift also asserted.
    capture(1'b0, 36'h0);
    shift(0, 20, 36'hF_FFFF_FFFF);
    RESET = 1'b1; JCE1 = 1'b1; JSHIFT = 1'b1; JUPDATE = 1'b1; JTDI = 1'b1;
    step();
    RESET = 1'b0; JCE1 = 1'b0; JSHIFT = 1'b0; JUPDATE = 1'b0; JTDI = 1'b0;
    check("mrst_dout", 64'(DATA_OUT), 64'h0);
    check("mrst_dv",   64'(DATA_VALID), 64'h0);
    check("mrst_lerr", 64'(LEN_ERR), 64'h0);
    check("mrst_tdo",  64'(JTDO1), 64'h0);
    check("mrst_cnt",  64'(dut.u_cnt.count), 64'd0);
    update();
    check("mrst_upd_dv",    64'(DATA_VALID), 64'h0);
    check("mrst_upd_state", 64'(dut.state_q), 64'(ST_IDLE));
    step();
    check("mrst_upd_dout",  64'(DATA_OUT), 64'h0);

    // RTI pulse on first cycle of a 5-cycle assertion only.
    JRTI1 = 1'b1;
    step();
    check("rti_first", 64'(RTI_PULSE), 64'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("rti_hold", 64'(RTI_PULSE), 64'h0);
    end
    JRTI1 = 1'b0;
    step();
    check("rti_off", 64'(RTI_PULSE), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
